bcd_pair_converter: RTL and testbench

Sequential binary-to-BCD converter that turns two 16-bit binary operands into two 4-digit BCD numbers for the LCD display stage. It sits directly upstream of the LCD top level. Its eight 4-bit digit outputs connect one-to-one to that stage's Thousands/Hundreds/Tens/Ones inputs for Num1 and Num2. It uses iterative shift-add-3 (double dabble), one bit per clock, and converts both operands in parallel.

---
 rtl/bcd_pair_converter.sv | 180 ++++++++++++++++++
 tb/tb_bcd_pair_converter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_pair_converter.sv
// bcd_pair_converter
// Converts two 16-bit binary operands into two 4-digit BCD numbers for the LCD
// display stage. It uses shift-add-3 (double dabble), one bit per clock, and
// handles both operands in parallel. A conversion takes 17 cycles from the
// Start sample to the Done pulse.
//
// Ports:
//   CLOCK_50                 system clock, rising edge
//   RST                      synchronous active-high reset
//   Start                    conversion request, sampled only while idle
//   Num1, Num2               16-bit binary operands
//   Busy                     high while a conversion is in progress
//   Done                     one-cycle pulse when new results are valid
//   ThousandsBin1..OnesBin1  BCD digits of operand 1
//   ThousandsBin2..OnesBin2  BCD digits of operand 2
//   Ovf1, Ovf2               magnitude above 9999; digits saturated to 9999
//   Neg1, Neg2               operand was negative (SIGNED_IN=1 only)
module bcd_pair_converter #(
    parameter bit SIGNED_IN = 1'b0
) (
    input  logic        CLOCK_50,
    input  logic        RST,
    input  logic        Start,
    input  logic [15:0] Num1,
    input  logic [15:0] Num2,
    output logic        Busy,
    output logic        Done,
    output logic [3:0]  ThousandsBin1,
    output logic [3:0]  HundredsBin1,
    output logic [3:0]  TensBin1,
    output logic [3:0]  OnesBin1,
    output logic [3:0]  ThousandsBin2,
    output logic [3:0]  HundredsBin2,
    output logic [3:0]  TensBin2,
    output logic [3:0]  OnesBin2,
    output logic        Ovf1,
    output logic        Ovf2,
    output logic        Neg1,
    output logic        Neg2
);

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned DIGITS   = 5;
    localparam int unsigned BCD_W    = 4 * DIGITS;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned OUT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [OUT_W-1:0] SAT_DIGITS = 16'h9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD_OUT
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   sr1, sr2;
    logic [BCD_W-1:0]    acc1, acc2;
    logic [BCD_W-1:0]    acc1_adj, acc2_adj;
    logic [CNT_W-1:0]    cnt;
    logic                sign1, sign2;
    logic [OUT_W-1:0]    dig1, dig2;

    // Operand sign: only meaningful in two's-complement mode.
    function automatic logic is_neg(input logic [DATA_W-1:0] v);
        return SIGNED_IN & v[DATA_W-1];
    endfunction

    // Magnitude of the operand; -32768 maps to 32768 and saturates later.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        if (is_neg(v)) begin
            return DATA_W'(~v + DATA_W'(1));
        end
        return v;
    endfunction

    // Add 3 to every digit >= 5 so the following shift carries correctly.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] r;
        r = acc;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = 4'(acc[4*d +: 4] + 4'd3);
            end
        end
        return r;
    endfunction

    assign acc1_adj = add3(acc1);
    assign acc2_adj = add3(acc2);

    // Digit outputs are slices of the result registers.
    assign ThousandsBin1 = dig1[15:12];
    assign HundredsBin1  = dig1[11:8];
    assign TensBin1      = dig1[7:4];
    assign OnesBin1      = dig1[3:0];
    assign ThousandsBin2 = dig2[15:12];
    assign HundredsBin2  = dig2[11:8];
    assign TensBin2      = dig2[7:4];
    assign OnesBin2      = dig2[3:0];

    // Control FSM and datapath.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state <= IDLE;
            sr1   <= '0;
            sr2   <= '0;
            acc1  <= '0;
            acc2  <= '0;
            cnt   <= '0;
            sign1 <= 1'b0;
            sign2 <= 1'b0;
            dig1  <= '0;
            dig2  <= '0;
            Ovf1  <= 1'b0;
            Ovf2  <= 1'b0;
            Neg1  <= 1'b0;
            Neg2  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        sr1   <= magnitude(Num1);
                        sr2   <= magnitude(Num2);
                        sign1 <= is_neg(Num1);
                        sign2 <= is_neg(Num2);
                        acc1  <= '0;
                        acc2  <= '0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Adjusted accumulator's top bit is always 0 for 16-bit inputs.
                    acc1  <= BCD_W'({acc1_adj, sr1[DATA_W-1]});
                    acc2  <= BCD_W'({acc2_adj, sr2[DATA_W-1]});
                    sr1   <= {sr1[DATA_W-2:0], 1'b0};
                    sr2   <= {sr2[DATA_W-2:0], 1'b0};
                    cnt   <= CNT_W'(cnt + CNT_W'(1));
                    if (cnt == CNT_LAST) begin
                        state <= LOAD_OUT;
                    end
                end

                LOAD_OUT: begin
                    // A non-zero ten-thousands digit means the value exceeds 9999.
                    if (acc1[BCD_W-1 -: 4] != 4'd0) begin
                        dig1 <= SAT_DIGITS;
                        Ovf1 <= 1'b1;
                    end else begin
                        dig1 <= acc1[OUT_W-1:0];
                        Ovf1 <= 1'b0;
                    end
                    if (acc2[BCD_W-1 -: 4] != 4'd0) begin
                        dig2 <= SAT_DIGITS;
                        Ovf2 <= 1'b1;
                    end else begin
                        dig2 <= acc2[OUT_W-1:0];
                        Ovf2 <= 1'b0;
                    end
                    Neg1  <= sign1;
                    Neg2  <= sign2;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_pair_converter.sv
// Testbench for bcd_pair_converter: one instance per SIGNED_IN setting, driven
// by a linear sequence of directed steps plus a random regression against a
// decimal reference model.
module tb_bcd_pair_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic [15:0] n1 [2];
    logic [15:0] n2 [2];
    logic        busy [2];
    logic        done [2];
    logic [3:0]  th1 [2], hu1 [2], te1 [2], on1 [2];
    logic [3:0]  th2 [2], hu2 [2], te2 [2], on2 [2];
    logic        ovf1 [2], ovf2 [2], neg1 [2], neg2 [2];

    int checks = 0;
    int fails  = 0;
    int lat;

    always #5 clk = ~clk;

    bcd_pair_converter #(.SIGNED_IN(1'b0)) dut_u (
        .CLOCK_50(clk), .RST(rst), .Start(start[0]), .Num1(n1[0]), .Num2(n2[0]),
        .Busy(busy[0]), .Done(done[0]),
        .ThousandsBin1(th1[0]), .HundredsBin1(hu1[0]), .TensBin1(te1[0]), .OnesBin1(on1[0]),
        .ThousandsBin2(th2[0]), .HundredsBin2(hu2[0]), .TensBin2(te2[0]), .OnesBin2(on2[0]),
        .Ovf1(ovf1[0]), .Ovf2(ovf2[0]), .Neg1(neg1[0]), .Neg2(neg2[0])
    );

    bcd_pair_converter #(.SIGNED_IN(1'b1)) dut_s (
        .CLOCK_50(clk), .RST(rst), .Start(start[1]), .Num1(n1[1]), .Num2(n2[1]),
        .Busy(busy[1]), .Done(done[1]),
        .ThousandsBin1(th1[1]), .HundredsBin1(hu1[1]), .TensBin1(te1[1]), .OnesBin1(on1[1]),
        .ThousandsBin2(th2[1]), .HundredsBin2(hu2[1]), .TensBin2(te2[1]), .OnesBin2(on2[1]),
        .Ovf1(ovf1[1]), .Ovf2(ovf2[1]), .Neg1(neg1[1]), .Neg2(neg2[1])
    );

    // Result view: digits1, digits2, {ovf1, ovf2, neg1, neg2}.
    function automatic logic [35:0] res(input int i);
        return {th1[i], hu1[i], te1[i], on1[i], th2[i], hu2[i], te2[i], on2[i],
                ovf1[i], ovf2[i], neg1[i], neg2[i]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input int i, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [3:0] flags);
        check(tag, 64'(res(i)), 64'({d1, d2, flags}));
    endtask

    // Decimal reference: magnitude via integer arithmetic, digits via / and %.
    task automatic model(input logic [15:0] v, input bit sgn, output logic [15:0] d,
                         output logic ovf, output logic neg);
        int m;
        neg = sgn && v[15];
        m = neg ? (65536 - int'(v)) : int'(v);
        ovf = (m > 9999);
        if (ovf) d = 16'h9999;
        else d = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endtask

    // Run one conversion on both instances; outputs must hold while busy.
    task automatic convert(input logic [15:0] a1, input logic [15:0] a2,
                           input logic [15:0] b1, input logic [15:0] b2);
        logic [35:0] snap0, snap1;
        @(negedge clk);
        n1[0] = a1; n2[0] = a2; n1[1] = b1; n2[1] = b2;
        start[0] = 1'b1; start[1] = 1'b1;
        snap0 = res(0);
        snap1 = res(1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start[0] = 1'b0; start[1] = 1'b0;
                n1[0] = ~a1; n2[0] = ~a2; n1[1] = ~b1; n2[1] = ~b2;
            end
            if (done[0] === 1'b1) begin
                lat = i - 1;
                break;
            end
            check("busy_during_conv", {62'd0, busy[0], busy[1]}, 64'd3);
            check("hold_u", 64'(res(0)), 64'(snap0));
            check("hold_s", 64'(res(1)), 64'(snap1));
        end
        check("latency", 64'(lat), 64'd17);
        check("done_both", {62'd0, done[0], done[1]}, 64'd3);
        check("busy_off_at_done", {62'd0, busy[0], busy[1]}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {62'd0, done[0], done[1]}, 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b, ed1, ed2;
        logic        eo1, eo2, en1, en2;
        int          ndone, t[3];

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; n1[i] = 16'd0; n2[i] = 16'd0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_u", 64'({busy[0], done[0], res(0)}), 64'd0);
        check("reset_s", 64'({busy[1], done[1], res(1)}), 64'd0);
        rst = 1'b0;

        // Basic conversion
        convert(16'd1234, 16'd5678, 16'd1234, 16'd5678);
        check_res("conv_1234_5678_u", 0, 16'h1234, 16'h5678, 4'b0000);
        check_res("conv_1234_5678_s", 1, 16'h1234, 16'h5678, 4'b0000);

        // Boundaries
        convert(16'd0, 16'd9999, 16'd0, 16'd9999);
        check_res("bound_0_9999_u", 0, 16'h0000, 16'h9999, 4'b0000);
        check_res("bound_0_9999_s", 1, 16'h0000, 16'h9999, 4'b0000);
        convert(16'd10000, 16'd65535, 16'd10000, 16'd65535);
        check_res("ovf_10000_65535_u", 0, 16'h9999, 16'h9999, 4'b1100);
        check_res("ovf_10000_minus1_s", 1, 16'h9999, 16'h0001, 4'b1001);

        // Signed operands
        convert(16'hFFD6, 16'h8000, 16'hFFD6, 16'h8000);
        check_res("ffd6_8000_u", 0, 16'h9999, 16'h9999, 4'b1100);
        check_res("minus42_minus32768_s", 1, 16'h0042, 16'h9999, 4'b0111);
        convert(16'd100, 16'd100, 16'd100, 16'd100);
        check_res("pos100_u", 0, 16'h0100, 16'h0100, 4'b0000);
        check_res("pos100_s", 1, 16'h0100, 16'h0100, 4'b0000);

        // Start pulsed mid-conversion with a changed operand is ignored
        @(negedge clk);
        n1[0] = 16'd1234; n2[0] = 16'd0; start[0] = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 1) start[0] = 1'b0;
            if (i == 5) begin start[0] = 1'b1; n1[0] = 16'd4321; end
            if (i == 6) start[0] = 1'b0;
            if (done[0] === 1'b1) ndone++;
        end
        check("busy_start_one_done", 64'(ndone), 64'd1);
        check_res("busy_start_result", 0, 16'h1234, 16'h0000, 4'b0000);

        // Start held high: Done every 18 cycles
        @(negedge clk);
        n1[0] = 16'd7; n2[0] = 16'd8; start[0] = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 70 && ndone < 3; i++) begin
            @(negedge clk);
            if (done[0] === 1'b1) begin
                t[ndone] = i;
                ndone++;
                if (ndone == 3) start[0] = 1'b0;
            end
        end
        check("held_done_count", 64'(ndone), 64'd3);
        check("held_first_done", 64'(t[0]), 64'd18);
        check("held_spacing_1", 64'(t[1] - t[0]), 64'd18);
        check("held_spacing_2", 64'(t[2] - t[1]), 64'd18);
        check_res("held_result", 0, 16'h0007, 16'h0008, 4'b0000);
        repeat (20) @(negedge clk);
        check("held_no_extra", {63'd0, busy[0]}, 64'd0);

        // Reset in the middle of a conversion
        convert(16'd5678, 16'd5678, 16'd5678, 16'd5678);
        check_res("pre_reset_result", 0, 16'h5678, 16'h5678, 4'b0000);
        @(negedge clk);
        n1[0] = 16'd1234; n2[0] = 16'd1234; start[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midreset_u", 64'({busy[0], done[0], res(0)}), 64'd0);
        check("midreset_s", 64'({busy[1], done[1], res(1)}), 64'd0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done[0] === 1'b1) ndone++;
        end
        check("midreset_no_done", 64'(ndone), 64'd0);
        convert(16'd42, 16'd0, 16'd42, 16'd0);
        check_res("after_reset_42_u", 0, 16'h0042, 16'h0000, 4'b0000);
        check_res("after_reset_42_s", 1, 16'h0042, 16'h0000, 4'b0000);

        // Random regression against the decimal model
        for (int k = 0; k < 1000; k++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 10050)) : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(55486, 65535)) : 16'($urandom);
            convert(a, b, a, b);
            for (int i = 0; i < 2; i++) begin
                model(a, i == 1, ed1, eo1, en1);
                model(b, i == 1, ed2, eo2, en2);
                check_res(i == 0 ? "rand_u" : "rand_s", i, ed1, ed2, {eo1, eo2, en1, en2});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
